gray_capture: RTL
=================

GRAY_CAPTURE -- requirements
Module: gray_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the Gray input and binary output width.
REQ-002 SHALL have parameter STABLE_CYCLES, default 2, giving the consecutive equal samples needed to accept a value; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port enable  input  1  capture enable.
REQ-006 SHALL have port gray_in  input  WIDTH  Gray count produced by the upstream pulse counter; may be asynchronous to clk.
REQ-007 SHALL have port out_ready  input  1  downstream consumer accepts bin_out.
REQ-008 SHALL have port bin_out  output  WIDTH  binary value of the accepted Gray code, registered.
REQ-009 SHALL have port out_valid  output  1  bin_out holds an unconsumed result.
REQ-010 SHALL have port glitch_err  output  1  sticky flag: an illegal Gray transition was seen.
REQ-011 SHALL have port drop_cnt  output  4  saturating count of accepted values lost because the output was still occupied.

Function
REQ-012 SHALL sample gray_in through a two-register synchroniser (s1, then s2) every cycle, independent of enable.
REQ-013 SHALL hold a candidate register cand and a stability counter cnt (0..STABLE_CYCLES, saturating).
REQ-014 SHALL, while enable=0, load cand<=s2 and cnt<=0 every cycle, and perform no glitch check and no acceptance.
REQ-015 SHALL, while enable=1 and s2!=cand, load cand<=s2 and cnt<=1.
REQ-016 SHALL, while enable=1 and s2==cand and cnt<STABLE_CYCLES, increment cnt.
REQ-017 SHALL raise an accept event only on the cycle cnt transitions to STABLE_CYCLES; a held-stable input SHALL produce exactly one event.
REQ-018 SHALL, while enable=1 and s2!=cand, set glitch_err=1 when popcount(s2 XOR cand)!=1; glitch_err SHALL stay set until reset.
REQ-019 SHALL keep a last-accepted register last, reset to 0; an event with cand==last SHALL be ignored, so Gray 0 after reset is never reported.
REQ-020 SHALL, on an event with cand!=last and (out_valid=0 or out_ready=1), load bin_out<=gray-to-binary(cand), set out_valid=1 and set last<=cand.
REQ-021 SHALL, on an event with cand!=last and out_valid=1 and out_ready=0, keep bin_out unchanged, set last<=cand, and increment drop_cnt, saturating at 15.
REQ-022 SHALL clear out_valid on out_valid=1 and out_ready=1 with no simultaneous load; when a load coincides, out_valid SHALL stay 1 carrying the new value.
REQ-023 SHALL keep bin_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL use gray-to-binary as b[WIDTH-1]=g[WIDTH-1] and b[i]=b[i+1] XOR g[i].
REQ-025 SHALL give latency: gray_in constant from the edge E0 where s1 first captures it (enable=1) gives out_valid=1 after edge E0+STABLE_CYCLES+2.
REQ-026 SHALL let the handshake (REQ-022) operate regardless of enable.

Reset
REQ-027 SHALL, on reset_n=0, immediately clear s1, s2, cand, cnt, last, bin_out, out_valid, glitch_err and drop_cnt to 0.
REQ-028 SHALL, when reset is asserted mid-acceptance or while out_valid=1, discard the pending result with no report after release.
REQ-029 SHALL release reset synchronously to clk: the first state change occurs no earlier than the first rising edge after reset_n rises.

Verification
REQ-030 SHALL cover basic capture: enable=1, out_ready=1, gray_in 0x00->0x03 held -> out_valid pulses for 1 cycle at E0+4 with bin_out=0x02; glitch_err=0.
REQ-031 SHALL cover backpressure and drop: out_ready=0, gray_in 0x03 then 0x02 each held 8 cycles -> bin_out stays 0x02, drop_cnt=1; then out_ready=1 -> out_valid falls.
REQ-032 SHALL cover a glitch: gray_in 0x01->0x02 directly -> glitch_err=1 and stays set through later legal steps until reset_n=0.
REQ-033 SHALL cover an MSB code: gray_in 0x80 held -> bin_out=0xFF; holding 40 cycles more gives no second out_valid.
REQ-034 SHALL cover enable gating: enable=0 while gray_in 0x03->0x06 -> no out_valid and no glitch_err; enable=1 -> bin_out=0x04 after STABLE_CYCLES+1 edges.
REQ-035 SHALL cover reset mid-operation: reset_n=0 one cycle before the expected out_valid -> all outputs 0 immediately, and no report after release for the same held input 0x00.

Source files
------------

// File: rtl/gray_capture.sv
// Captures a free-running Gray count from another domain: synchronises it, waits for it to
// settle, converts it to binary and hands it to a valid/ready consumer.
module gray_capture #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             glitch_err,
    output logic [3:0]       drop_cnt
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept_q, accept_d;
    logic             glitch_q, glitch_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic [3:0]       drop_q, drop_d;

    logic new_value, load, drop;

    // Stability filter: accept_d fires only on the cycle the counter reaches STABLE.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        glitch_d = glitch_q;
        if (!enable) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (s2_q != cand_q) begin
            cand_d   = s2_q;
            cnt_d    = 4'd1;
            accept_d = (STABLE == 4'd1);
            if ($countones(s2_q ^ cand_q) != 1) begin
                glitch_d = 1'b1;
            end
        end else if (cnt_q < STABLE) begin
            cnt_d    = cnt_q + 4'd1;
            accept_d = ((cnt_q + 4'd1) == STABLE);
        end
    end

    // A repeat of the last accepted code is not a new count and is never reported.
    assign new_value = accept_q && (cand_q != last_q);
    assign load      = new_value && (!valid_q || out_ready);
    assign drop      = new_value && valid_q && !out_ready;

    always_comb begin
        bin_d   = bin_q;
        valid_d = valid_q;
        last_d  = last_q;
        drop_d  = drop_q;
        if (load) begin
            bin_d   = gray_to_bin(cand_q);
            valid_d = 1'b1;
            last_d  = cand_q;
        end else if (drop) begin
            last_d = cand_q;
            if (drop_q != 4'hF) begin
                drop_d = drop_q + 4'd1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            accept_q <= 1'b0;
            glitch_q <= 1'b0;
            last_q   <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            drop_q   <= '0;
        end else begin
            s1_q     <= gray_in;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            accept_q <= accept_d;
            glitch_q <= glitch_d;
            last_q   <= last_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

    assign bin_out    = bin_q;
    assign out_valid  = valid_q;
    assign glitch_err = glitch_q;
    assign drop_cnt   = drop_q;

endmodule
